// File: rtl/mips_pipe_core.sv
// Four-stage (IF/ID/EX/WB) 16-bit-instruction MIPS subset core, falling-edge clocked.
// Full bypass: EX/WB result forwarded into EX, register-file write-through into ID.
module mips_pipe_core #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-2:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [PC_W-1:0]   PC,
  output logic [15:0]       IFID_IR,
  output logic [15:0]       IDEX_IR,
  output logic              wb_we,
  output logic [1:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              branch_taken
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;

  logic [PC_W-1:0]          pc_q, pc_d, ifid_pc_q, ifid_pc_d, idex_pc_q, idex_pc_d;
  logic [15:0]              ifid_ir_q, ifid_ir_d, idex_ir_q, idex_ir_d;
  logic [DATA_W-1:0]        idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic                     wb_we_q, wb_we_d;
  logic [1:0]               wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]        wb_data_q, wb_data_d;
  logic [3:0][DATA_W-1:0]   rf_q, rf_d;

  // ID read: the write committing on this same edge is seen by the reader.
  logic [1:0]        id_rs, id_rt;
  logic [DATA_W-1:0] id_a, id_b;
  assign id_rs = ifid_ir_q[11:10];
  assign id_rt = ifid_ir_q[9:8];
  assign id_a  = (id_rs == 2'd0) ? '0 :
                 (wb_we_q && wb_reg_q == id_rs) ? wb_data_q : rf_q[id_rs];
  assign id_b  = (id_rt == 2'd0) ? '0 :
                 (wb_we_q && wb_reg_q == id_rt) ? wb_data_q : rf_q[id_rt];

  logic [3:0]        ex_op;
  logic [1:0]        ex_rs, ex_rt, ex_rd, ex_dst;
  logic [DATA_W-1:0] ex_a, ex_b, ex_simm, ex_res;
  logic [PC_W-1:0]   br_off, br_target;
  logic              ex_we, br_cond;

  assign ex_op     = idex_ir_q[15:12];
  assign ex_rs     = idex_ir_q[11:10];
  assign ex_rt     = idex_ir_q[9:8];
  assign ex_rd     = idex_ir_q[7:6];
  assign ex_simm   = {{(DATA_W-8){idex_ir_q[7]}}, idex_ir_q[7:0]};
  assign ex_a      = (ex_rs != 2'd0 && wb_we_q && wb_reg_q == ex_rs) ? wb_data_q : idex_a_q;
  assign ex_b      = (ex_rt != 2'd0 && wb_we_q && wb_reg_q == ex_rt) ? wb_data_q : idex_b_q;
  assign br_off    = {{(PC_W-9){idex_ir_q[7]}}, idex_ir_q[7:0], 1'b0};
  assign br_target = idex_pc_q + PC_W'(2) + br_off;

  always_comb begin
    ex_res  = '0;
    ex_we   = 1'b0;
    ex_dst  = 2'd0;
    br_cond = 1'b0;
    case (ex_op)
      OP_ADD:  begin ex_res = ex_a + ex_b; ex_we = 1'b1; ex_dst = ex_rd; end
      OP_SUB:  begin ex_res = ex_a - ex_b; ex_we = 1'b1; ex_dst = ex_rd; end
      OP_AND:  begin ex_res = ex_a & ex_b; ex_we = 1'b1; ex_dst = ex_rd; end
      OP_OR:   begin ex_res = ex_a | ex_b; ex_we = 1'b1; ex_dst = ex_rd; end
      OP_SLT:  begin
        ex_res = {{(DATA_W-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
        ex_we  = 1'b1;
        ex_dst = ex_rd;
      end
      OP_ADDI: begin ex_res = ex_a + ex_simm; ex_we = 1'b1; ex_dst = ex_rt; end
      OP_BEQ:  br_cond = (ex_a == ex_b);
      OP_BNE:  br_cond = (ex_a != ex_b);
      default: ;
    endcase
  end

  assign branch_taken = run & br_cond;

  always_comb begin
    pc_d      = pc_q;
    ifid_ir_d = ifid_ir_q;
    ifid_pc_d = ifid_pc_q;
    idex_ir_d = idex_ir_q;
    idex_pc_d = idex_pc_q;
    idex_a_d  = idex_a_q;
    idex_b_d  = idex_b_q;
    wb_we_d   = wb_we_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    rf_d      = rf_q;
    if (run) begin
      // A taken branch squashes the two younger instructions behind it.
      pc_d      = branch_taken ? br_target : pc_q + PC_W'(2);
      ifid_ir_d = branch_taken ? 16'h0000 : imem_data;
      ifid_pc_d = pc_q;
      idex_ir_d = branch_taken ? 16'h0000 : ifid_ir_q;
      idex_pc_d = ifid_pc_q;
      idex_a_d  = id_a;
      idex_b_d  = id_b;
      wb_we_d   = ex_we;
      wb_reg_d  = ex_dst;
      wb_data_d = ex_we ? ex_res : '0;
      if (wb_we_q && wb_reg_q != 2'd0) rf_d[wb_reg_q] = wb_data_q;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      ifid_ir_q <= '0;
      ifid_pc_q <= '0;
      idex_ir_q <= '0;
      idex_pc_q <= '0;
      idex_a_q  <= '0;
      idex_b_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      rf_q      <= '0;
    end else begin
      pc_q      <= pc_d;
      ifid_ir_q <= ifid_ir_d;
      ifid_pc_q <= ifid_pc_d;
      idex_ir_q <= idex_ir_d;
      idex_pc_q <= idex_pc_d;
      idex_a_q  <= idex_a_d;
      idex_b_q  <= idex_b_d;
      wb_we_q   <= wb_we_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      rf_q      <= rf_d;
    end
  end

  assign imem_addr = pc_q[PC_W-1:1];
  assign PC        = pc_q;
  assign IFID_IR   = ifid_ir_q;
  assign IDEX_IR   = idex_ir_q;
  assign wb_we     = wb_we_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mips_pipe_core.sv
// Scoreboard bench for mips_pipe_core: directed programs push expected register
// writes; a monitor pops and compares on every advancing write-back.
module tb_mips_pipe_core;
  localparam int DW = 32;
  localparam int PW = 16;

  logic          clock, reset, run;
  logic [PW-2:0] imem_addr;
  logic [15:0]   imem_data;
  logic [PW-1:0] PC;
  logic [15:0]   IFID_IR, IDEX_IR;
  logic          wb_we;
  logic [1:0]    wb_reg;
  logic [DW-1:0] wb_data;
  logic          branch_taken;

  mips_pipe_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data), .PC(PC),
    .IFID_IR(IFID_IR), .IDEX_IR(IDEX_IR),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .branch_taken(branch_taken)
  );

  logic [15:0] imem [0:63];
  assign imem_data = (imem_addr < 64) ? imem[imem_addr[5:0]] : 16'h0000;

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct { logic [1:0] r; logic [DW-1:0] d; } wr_t;
  wr_t         sb[$];
  logic [15:0] prog[$];
  int          n_chk = 0, n_fail = 0, br_cnt = 0;
  bit          adv = 1'b0, redir_pend = 1'b0;
  logic [PW-1:0] exp_target = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] rs, rt, rd);
    return {op, rs, rt, rd, 6'd0};
  endfunction
  function automatic logic [15:0] ii(input logic [3:0] op, input logic [1:0] rs, rt,
                                     input logic [7:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic exp_wr(input logic [1:0] r, input logic [DW-1:0] d);
    wr_t e;
    e.r = r; e.d = d;
    sb.push_back(e);
  endtask

  task automatic ld();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    prog.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic hazard_prog();
    prog = '{ii(4,0,1,15), ii(4,0,2,7), rr(2,1,2,3), rr(1,1,3,2),
             rr(3,2,3,2), rr(0,2,3,3), rr(7,3,2,1), rr(7,2,3,1)};
  endtask

  task automatic hazard_exp();
    exp_wr(1, 15); exp_wr(2, 7); exp_wr(3, 7); exp_wr(2, 8);
    exp_wr(2, 15); exp_wr(3, 22); exp_wr(1, 0); exp_wr(1, 1);
  endtask

  // Asynchronous reset (effect checked before any clock edge), then first fetch.
  task automatic start();
    reset = 1'b1;
    #1;
    chk("rst_pc", PC, 0);
    chk("rst_ifid", IFID_IR, 0);
    chk("rst_idex", IDEX_IR, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_reg", wb_reg, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_branch", branch_taken, 0);
    step(2);
    reset = 1'b0;
    run   = 1'b1;
    step(1);
    chk("first_fetch", IFID_IR, imem[0]);
    br_cnt = 0;
  endtask

  task automatic drain(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clock) adv = !reset && run;

  always @(posedge clock) begin
    if (redir_pend) begin
      chk("redirect_pc", PC, exp_target);
      chk("flush_ifid", IFID_IR, 0);
      chk("flush_idex", IDEX_IR, 0);
    end
    redir_pend = branch_taken;
    if (branch_taken) br_cnt++;
    if (adv && wb_we && wb_reg != 2'd0) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got reg %0d data %0h, expected none", wb_reg, wb_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wb_reg", wb_reg, e.r);
        chk("wb_data", wb_data, e.d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    step(1);

    // Hazard chain, zero nops
    hazard_prog(); ld(); hazard_exp();
    start(); step(13);
    drain("hazard_drain");

    // Partial chain, then reset mid-stream with live state
    hazard_prog(); ld();
    exp_wr(1, 15); exp_wr(2, 7); exp_wr(3, 7); exp_wr(2, 8); exp_wr(2, 15);
    start(); step(6);
    drain("partial_drain");

    // Registers cleared by reset: t1=15,t2=8,t3=7 were committed above
    prog = '{rr(0,1,2,1), rr(0,3,0,2)}; ld();
    exp_wr(1, 0); exp_wr(2, 0);
    start(); step(7);
    drain("rstclr_drain");

    // Register-file write-through at distance 2
    prog = '{ii(4,0,1,5), 16'h0000, rr(0,1,1,2)}; ld();
    exp_wr(1, 5); exp_wr(2, 10);
    start(); step(7);
    drain("wthru_drain");

    // $0 is never written nor forwarded
    prog = '{ii(4,0,0,9), rr(0,0,0,1)}; ld();
    exp_wr(1, 0);
    start(); step(7);
    drain("zero_drain");

    // beq taken: 4 and 6 flushed, target 8
    prog = '{ii(4,0,1,3), ii(5,1,1,2), ii(4,0,2,1), ii(4,0,2,2), ii(4,0,3,4), rr(0,2,0,1)};
    ld();
    exp_wr(1, 3); exp_wr(3, 4); exp_wr(1, 0);
    exp_target = 16'd8;
    start(); step(10);
    chk("beq_taken_cnt", br_cnt, 1);
    drain("beq_drain");

    // bne not taken: fall through
    prog = '{ii(4,0,1,3), ii(6,1,1,2), ii(4,0,2,1), ii(4,0,2,2), ii(4,0,3,4), rr(0,2,0,1)};
    ld();
    exp_wr(1, 3); exp_wr(2, 1); exp_wr(2, 2); exp_wr(3, 4); exp_wr(1, 2);
    start(); step(10);
    chk("bne_taken_cnt", br_cnt, 0);
    drain("bne_drain");

    // 32-bit sign extension and signed compare
    prog = '{ii(4,0,1,8'hFF), rr(7,1,0,2)}; ld();
    exp_wr(1, 32'hFFFF_FFFF); exp_wr(2, 1);
    start(); step(7);
    drain("w32_drain");

    // Freeze for 5 cycles after 4 fetches, then resume
    hazard_prog(); ld(); hazard_exp();
    start(); step(3);
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("frz_pc", PC, 16'd8);
      chk("frz_ifid", IFID_IR, imem[3]);
      chk("frz_idex", IDEX_IR, imem[2]);
      chk("frz_branch", branch_taken, 0);
    end
    run = 1'b1;
    step(13);
    drain("freeze_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_pipe_core.md
# mips_pipe_core

Parametrised four-stage (IF, ID, EX, WB) 16-bit-instruction MIPS subset core. It replaces the fixed three-stage, reset-less core. Additions: asynchronous reset, configurable data and PC width, full hazard-free forwarding (EX-stage bypass plus register-file write-through), taken-branch flush for beq/bne, a `run` freeze input, and an external instruction-memory port. It is the datapath top under the test module.

## Interface
- `DATA_W`, 16: register, ALU and write-back width (≥16).
- `PC_W`, 16: PC width in bits. Byte-addressed; the PC increments by 2.
- `clock` in 1: all state updates on the falling edge.
- `reset` in 1: asynchronous, active-high.
- `run` in 1: 1 = pipeline advances; 0 = PC, pipeline registers and register file hold.
- `imem_addr` out PC_W-1: instruction word index, equal to `PC[PC_W-1:1]`.
- `imem_data` in 16: instruction at `imem_addr`, combinational, same cycle.
- `PC` out PC_W: current fetch PC.
- `IFID_IR` out 16, `IDEX_IR` out 16: pipeline instruction monitors.
- `wb_we` out 1, `wb_reg` out 2, `wb_data` out DATA_W: the write-back stage register-file write.
- `branch_taken` out 1: EX-stage branch resolved taken this cycle.

## Operation
- Encoding: [15:12] op, [11:10] rs, [9:8] rt, [7:6] rd, [7:0] imm8, sign-extended to DATA_W.
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0111 slt: R-type, writes rd.
  - 0100 addi: writes rt = rs + simm.
  - 0101 beq, 0110 bne: compare rs and rt.
  - All other opcodes: nop, no write.
  - 16'h0000 is a nop.
- Register file: 4 × DATA_W.
  - $0 reads as 0 and writes to it are discarded.
  - All registers clear on reset.
- slt is a signed DATA_W compare, result 0 or 1. Arithmetic wraps mod 2^DATA_W.
- ID stage: reads the register file with write-through. If WB writes reg r (r≠0) on this edge and ID reads r, ID receives `wb_data`.
- EX stage forwarding, per operand: if EX/WB wrote reg r≠0 and IDEX source = r, take the EX/WB result; otherwise take the IDEX value. $0 is never forwarded.
- Branch:
  - Resolved in EX using the forwarded operands.
  - target = branch PC + 2 + (simm << 1), mod 2^PC_W.
  - Taken: PC ← target; IFID_IR and IDEX_IR ← 0 (nop, no write); `branch_taken` = 1 for that cycle.
  - Not taken: no effect.
- The branch itself does not write the register file.
- PC wraps from 2^PC_W−2 to 0.
- No stalls are ever inserted; there are no loads.

## Timing
- Reset (asynchronous assert, immediate):
  - PC = 0; IFID_IR = IDEX_IR = 0; EX/WB = bubble.
  - `wb_we` = 0, `wb_reg` = 0, `wb_data` = 0, `branch_taken` = 0, regs = 0.
- First fetch: the first falling edge with reset low and `run` = 1 captures `imem_data` at index 0 into IFID_IR.
- An instruction captured into IFID at edge n:
  - reaches IDEX at n+1;
  - reaches EX/WB at n+2 (`wb_*` valid between n+2 and n+3);
  - commits to the register file at n+3.
- Back-to-back dependents need zero nops: distance 1 via EX forwarding, distance 2 via write-through.
- Taken branch penalty: 2 bubbles. The target is in IFID at the edge after resolution.
- A branch in EX and a write in WB on the same edge: both take effect.
- `run` = 0: nothing updates, outputs are stable, and `branch_taken` is held at 0. Resuming continues exactly where it stopped.
- Reset mid-run: the pipeline is discarded immediately and the first fetch after release is index 0.

## Test plan
- Reset check: assert reset mid-program → all outputs 0 and regs 0 immediately. After release, the next IFID_IR = imem[0].
- Hazard chain, no nops:
  - Program: addi t1,15; addi t2,7; and t3=t1&t2; sub t2=t1−t3; or t2=t2|t3; add t3=t2+t3; slt t1=t3<t2; slt t1=t2<t3.
  - Required `wb_data` sequence: 15, 7, 7, 8, 15, 22, 0, 1.
- Write-through: addi t1,5; nop; add t2,t1,t1 → t2 = 10.
- $0 guard: addi $0,9 then add t1,$0,$0 → t1 = 0 (no forwarding from $0).
- Branch, taken case:
  - Program: addi t1,3 at 0; beq t1,t1,+2 at 2; addi t2,1 at 4; addi t2,2 at 6; addi t3,4 at 8.
  - Required: `branch_taken` = 1 for one cycle; instructions at 4 and 6 flushed (wb_we never set for them); t3 = 4; t2 unchanged at 0.
  - Repeat with bne in place of beq: no redirect.
- Parameter and freeze:
  - DATA_W = 32: addi t1,−1; slt t2,t1,$0 → t2 = 1, `wb_data` = 32'hFFFFFFFF.
  - `run` low for 5 cycles mid-stream → PC and all IRs hold; results match the uninterrupted run.
